// File: rtl/sort_reader.sv
// Read-back checker for the sorter's output memory: walks addresses 0..n-1,
// verifies non-decreasing unsigned order and accumulates min/max/checksum.
module sort_reader #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDRWIDTH-1:0]           n,
  output logic                           rd_en,
  output logic [ADDRWIDTH-1:0]           rd_addr,
  input  logic [DATAWIDTH-1:0]           rd_data,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [ADDRWIDTH-1:0]           err_count,
  output logic [ADDRWIDTH-1:0]           first_err_addr,
  output logic [DATAWIDTH-1:0]           min_val,
  output logic [DATAWIDTH-1:0]           max_val,
  output logic [DATAWIDTH+ADDRWIDTH-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDRWIDTH-1:0] ONE = ADDRWIDTH'(1);

  state_t                 state, state_nxt;
  logic [ADDRWIDTH-1:0]   n_q;
  logic                   vld_p0;
  logic [ADDRWIDTH-1:0]   idx_p0;
  logic [DATAWIDTH-1:0]   prev_q;
  logic                   is_err;
  logic [ADDRWIDTH-1:0]   err_nxt;

  function automatic logic [DATAWIDTH+ADDRWIDTH-1:0] cks_add(
    input logic [DATAWIDTH+ADDRWIDTH-1:0] acc,
    input logic [DATAWIDTH-1:0]           word
  );
    return acc + {{ADDRWIDTH{1'b0}}, word};
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (n == '0) ? DONE : READ;
      READ:  if (rd_addr == n_q - ONE) state_nxt = DRAIN;
      DRAIN: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_en = (state == READ);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  // Word returned this cycle is a descent if it is below its predecessor.
  assign is_err  = vld_p0 && (idx_p0 != '0) && (rd_data < prev_q);
  assign err_nxt = is_err ? err_count + ONE : err_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      n_q            <= '0;
      rd_addr        <= '0;
      vld_p0         <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      min_val        <= '0;
      max_val        <= '0;
      checksum       <= '0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= (state == READ);
      if (state == IDLE && start) begin
        n_q            <= n;
        rd_addr        <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
        checksum       <= '0;
        max_val        <= '0;
        if (n == '0) begin
          pass    <= 1'b1;
          min_val <= '0;
        end else begin
          pass    <= 1'b0;
          min_val <= '1;
        end
      end else begin
        if (state == READ) rd_addr <= rd_addr + ONE;
        if (vld_p0) begin
          checksum <= cks_add(checksum, rd_data);
          if (rd_data < min_val) min_val <= rd_data;
          if (rd_data > max_val) max_val <= rd_data;
          err_count <= err_nxt;
          if (is_err && err_count == '0) first_err_addr <= idx_p0;
        end
        if (state == DRAIN) pass <= (err_nxt == '0);
      end
    end
  end

  // p0 stage: address/data pipeline aligned with the one-cycle read latency
  always_ff @(posedge clk) begin
    idx_p0 <= rd_addr;
    if (vld_p0) prev_q <= rd_data;
  end

endmodule

// File: doc/sort_reader.md
# sort_reader

Read-back and checking engine for the sorter's output memory. After the sorter finishes, the block walks addresses 0..n-1 through a one-cycle-latency read port. It checks that the words are in non-decreasing unsigned order and reports pass/fail, error count, first offending address, min, max and checksum. It sits downstream of `sort_top` and is the consumer of the sorted memory that `sort_top` produces.

## Interface
- `DATAWIDTH`, default 8, width of each data word.
- `ADDRWIDTH`, default 9, width of `n`, the addresses and the error counters.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst`=0 resets on the next rising `clk`).
- `start`  in  1  one-cycle pulse meaning the sorter is done; sampled only in IDLE.
- `n`  in  ADDRWIDTH  element count; captured on the accepted `start`.
- `rd_en`  out  1  read strobe to the sorter memory.
- `rd_addr`  out  ADDRWIDTH  read address, valid while `rd_en`=1.
- `rd_data`  in  DATAWIDTH  memory word; valid the cycle after `rd_en`.
- `busy`  out  1  high from the accepted `start` until `done`, inclusive of the DONE cycle.
- `done`  out  1  one-cycle pulse; all results are valid from this cycle.
- `pass`  out  1  1 when zero ordering errors were found.
- `err_count`  out  ADDRWIDTH  number of indices i≥1 with word[i] < word[i-1].
- `first_err_addr`  out  ADDRWIDTH  smallest such i; 0 if none.
- `min_val`, `max_val`  out  DATAWIDTH  min/max over the n words.
- `checksum`  out  DATAWIDTH+ADDRWIDTH  sum of the words, modulo 2^(DATAWIDTH+ADDRWIDTH).

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE → READ on `start`=1 when n≠0.
  - Latch n; set `rd_addr`=0.
  - Clear `err_count`, `first_err_addr`, `checksum`.
  - Set `min_val` to all-ones and `max_val` to 0.
  - Clear `pass`.
- IDLE → DONE on `start`=1 when n=0.
  - Results: `pass`=1, `err_count`=0, `first_err_addr`=0, `min_val`=0, `max_val`=0, `checksum`=0.
- READ: `rd_en`=1 for each cycle; `rd_addr` increments by 1 per cycle.
  - After the read of address n-1 is issued, move to DRAIN.
- DRAIN: lasts one cycle, `rd_en`=0; the final word is consumed; then go to DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
  - `pass` = (`err_count`==0).
- Processing of each returned word, on the cycle after its `rd_en`:
  - Compare against the previous word for index ≥1 (unsigned compare).
  - On an error: increment `err_count`; if it was the first error, load `first_err_addr` with the index.
  - Update min, max and checksum.
  - The previous-word register is loaded every processed word.
- Equal adjacent words are legal (stable order), not errors.
- `start` while busy is ignored; the `n` input is ignored after capture.
- Results hold their values from `done` until the next accepted `start`. During `busy` they are intermediate and undefined for consumers.
- Reset (any state, including mid-READ) applies on the next edge:
  - State returns to IDLE; in-flight reads are discarded.
  - Reset values: `rd_en`=0, `rd_addr`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_addr`=0, `min_val`=0, `max_val`=0, `checksum`=0.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- For n≥1:
  - `rd_en`=1 in cycles 1..n, with `rd_addr`=k-1 in cycle k.
  - `rd_data` for address a is presented in cycle a+2.
  - DRAIN occupies cycle n+1; `done`=1 in cycle n+2.
  - Total latency from `start` to `done` is n+2 cycles.
- For n=0: `done`=1 in cycle 1.
- `busy`=1 in cycles 1 through the `done` cycle inclusive.
- A new `start` is accepted no earlier than the cycle after `done`, i.e. back-to-back runs cost one IDLE cycle.
- Reads issue at full throughput: one per cycle with no bubbles.
- Default widths: 511×255 < 2^17, so the checksum never wraps.

## Test plan
- Ascending memory 0..31, n=32, `start` pulse:
  - `rd_en` high exactly 32 cycles; `done` 34 cycles after `start`.
  - `pass`=1, `err_count`=0, `min_val`=0, `max_val`=31, `checksum`=496.
- Memory {5,5,3,9,1,9}, n=6:
  - `err_count`=2, `first_err_addr`=2, `pass`=0, `min_val`=1, `max_val`=9, `checksum`=32.
- n=0: `done` in cycle 1, `pass`=1, no `rd_en` ever asserted.
- n=1, word 0xFF: `done` in cycle 3, `pass`=1, `min_val`=`max_val`=0xFF, `checksum`=255.
- Second `start` in cycle 5 of a 32-word run: ignored; only one `done`.
  - Immediately after `done`, a new `start` with n=4 produces correct fresh results.
- `rst`=0 in cycle 10 of a 32-word run:
  - All outputs at reset values on the next edge; no `done`.
  - A following run with n=32 completes normally.
